// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT(U)/DIV(U) unit with architectural HI/LO
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        request an operation (sampled only in IDLE)
//   op           00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   a, b         rs / rt operands (multiplicand/dividend, multiplier/divisor)
//   hi_we, lo_we MTHI / MTLO write enables, honoured only in IDLE
//   wdata        data for MTHI / MTLO
//   busy         high from the cycle after accept until the done cycle
//   done         one-cycle pulse, hi/lo valid in the same cycle
//   div_by_zero  set with done when a divide had b == 0
//   hi, lo       HI / LO registers
//
// Build option: MULDIV_SIGNED_EN enables signed MULT/DIV (op[1] = 1).
// Without it op[1] is ignored and every operation is unsigned.

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    counter;
    logic             is_div;
    logic             b_zero;
    logic [WIDTH-1:0] operand;   // multiplicand for mul, divisor for div
    logic [WIDTH-1:0] work_hi;   // partial product high / partial remainder
    logic [WIDTH-1:0] work_lo;   // multiplier -> product low / dividend -> quotient

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

`ifdef MULDIV_SIGNED_EN
    logic neg_res;   // product/quotient sign: operand signs differ
    logic neg_rem;   // remainder follows the dividend sign
    logic a_neg_in;
    logic b_neg_in;

    assign a_neg_in = op[1] & a[WIDTH-1];
    assign b_neg_in = op[1] & b[WIDTH-1];
    assign a_mag    = a_neg_in ? (~a + 1'b1) : a;
    assign b_mag    = b_neg_in ? (~b + 1'b1) : b;
`else
    assign a_mag = a;
    assign b_mag = b;
`endif

    // One datapath step, shared registers for both operations.
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_diff;
    logic           div_ge;

    always_comb begin
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        div_shift = {work_hi, work_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand};
        div_ge    = (div_shift >= {1'b0, operand});
    end

    // Final sign correction and divide-by-zero override.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    always_comb begin
        prod = {work_hi, work_lo};
        quo  = work_lo;
        rem  = work_hi;
`ifdef MULDIV_SIGNED_EN
        if (neg_res) begin
            prod = ~prod + 1'b1;
            quo  = ~quo + 1'b1;
        end
        // With b == 0 the remainder equals |a|, so restoring the dividend
        // sign gives back a unchanged.
        if (neg_rem) begin
            rem = ~rem + 1'b1;
        end
`endif
        if (b_zero) begin
            quo = {WIDTH{1'b1}};
        end
        if (is_div) begin
            res_hi = rem;
            res_lo = quo;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            counter     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            is_div      <= 1'b0;
            b_zero      <= 1'b0;
            operand     <= '0;
            work_hi     <= '0;
            work_lo     <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        counter <= '0;
                        is_div  <= op[0];
                        b_zero  <= op[0] && (b == '0);
                        work_hi <= '0;
`ifdef MULDIV_SIGNED_EN
                        neg_res <= a_neg_in ^ b_neg_in;
                        neg_rem <= a_neg_in;
`endif
                        if (op[0]) begin
                            work_lo <= a_mag;
                            operand <= b_mag;
                        end else begin
                            work_lo <= b_mag;
                            operand <= a_mag;
                        end
                    end
                end
                RUN: begin
                    if (is_div) begin
                        work_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        work_lo <= {work_lo[WIDTH-2:0], div_ge};
                    end else begin
                        {work_hi, work_lo} <= {mul_sum, work_lo[WIDTH-1:1]};
                    end
                    counter <= counter + 1'b1;
                    if (counter == LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    hi          <= res_hi;
                    lo          <= res_lo;
                    div_by_zero <= b_zero;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    counter     <= '0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit

module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    // Issue one operation and wait for done; lat = edges from accept to done
    // (-1 if done never arrives). Returns #1 after the edge that raised done.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, output int lat);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %h want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %h want 0", done); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz got %h want 0", div_by_zero); end
        n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got %h want 0", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got %h want 0", lo); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_multu();
        int lat;
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL multu_latency got %0d want 33", lat); end
        n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi got %h want fffffffe", hi); end
        n_cmp++; if (lo !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo got %h want 00000001", lo); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle got %h want 0", done); end
    endtask

    task automatic test_divu();
        int lat;
        run_op(2'b01, 32'd100, 32'd7, lat);
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL divu_latency got %0d want 33", lat); end
        n_cmp++; if (lo !== 32'h0000_000E) begin n_err++; $display("FAIL divu_lo got %h want 0000000e", lo); end
        n_cmp++; if (hi !== 32'h0000_0002) begin n_err++; $display("FAIL divu_hi got %h want 00000002", hi); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL divu_dbz got %h want 0", div_by_zero); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL divu_busy_done got %h want 0", busy); end
    endtask

    task automatic test_div_zero();
        int lat;
        run_op(2'b01, 32'h0000_1234, 32'h0, lat);
        n_cmp++; if (hi !== 32'h0000_1234) begin n_err++; $display("FAIL dz_hi got %h want 00001234", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL dz_lo got %h want ffffffff", lo); end
        n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dz_flag got %h want 1", div_by_zero); end
        // start in the done cycle must be accepted
        op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL start_in_done got %h want 1", busy); end
        lat = -1;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk); #1;
            if (done) begin lat = e; break; end
        end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL dz_mul_latency got %0d want 33", lat); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL dz_clear got %h want 0", div_by_zero); end
        n_cmp++; if (lo !== 32'd6) begin n_err++; $display("FAIL dz_mul_lo got %h want 00000006", lo); end
        n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL dz_mul_hi got %h want 00000000", hi); end
    endtask

    task automatic test_signed();
        int lat;
`ifdef MULDIV_SIGNED_EN
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat);
        n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_s_lo got %h want fffffffd", lo); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_s_hi got %h want ffffffff", hi); end
        run_op(2'b10, 32'hFFFF_FFFD, 32'd5, lat);
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mul_s_hi got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFF1) begin n_err++; $display("FAIL mul_s_lo got %h want fffffff1", lo); end
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        n_cmp++; if (lo !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
        n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL div_ovf_hi got %h want 00000000", hi); end
`else
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, lat);
        n_cmp++; if (lo !== 32'h7FFF_FFFC) begin n_err++; $display("FAIL div_u_lo got %h want 7ffffffc", lo); end
        n_cmp++; if (hi !== 32'h0000_0001) begin n_err++; $display("FAIL div_u_hi got %h want 00000001", hi); end
        run_op(2'b10, 32'hFFFF_FFFD, 32'd5, lat);
        n_cmp++; if (hi !== 32'h0000_0004) begin n_err++; $display("FAIL mul_u_hi got %h want 00000004", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFF1) begin n_err++; $display("FAIL mul_u_lo got %h want fffffff1", lo); end
`endif
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL signed_latency got %0d want 33", lat); end
    endtask

    task automatic test_ignore_and_reset();
        int edges;
        int lat;
        @(negedge clk);
        op = 2'b00; a = 32'd1000; b = 32'd1000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0;  // must not disturb the run
        repeat (4) @(posedge clk);
        @(negedge clk);
        op = 2'b01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 5;
        lat = -1;
        while (edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (done) begin lat = edges; break; end
        end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL ignore_latency got %0d want 33", lat); end
        n_cmp++; if (lo !== 32'h000F_4240) begin n_err++; $display("FAIL ignore_lo got %h want 000f4240", lo); end
        n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL ignore_hi got %h want 00000000", hi); end
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_no_queue got %h want 0", busy); end

        @(negedge clk);
        op = 2'b00; a = 32'd1000; b = 32'd1000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy got %h want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midreset_done got %h want 0", done); end
        n_cmp++; if (lo !== 32'h0) begin n_err++; $display("FAIL midreset_lo got %h want 00000000", lo); end
        n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL midreset_hi got %h want 00000000", hi); end
        @(negedge clk);
        reset = 1'b1;
        run_op(2'b01, 32'd9, 32'd3, lat);
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL after_reset_latency got %0d want 33", lat); end
        n_cmp++; if (lo !== 32'd3) begin n_err++; $display("FAIL after_reset_lo got %h want 00000003", lo); end
        n_cmp++; if (hi !== 32'd0) begin n_err++; $display("FAIL after_reset_hi got %h want 00000000", hi); end
    endtask

    task automatic test_mthi_mtlo();
        int lat;
        @(negedge clk);
        hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        hi_we = 1'b0;
        n_cmp++; if (hi !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL mthi got %h want a5a5a5a5", hi); end
        n_cmp++; if (lo !== 32'd3) begin n_err++; $display("FAIL mthi_lo_kept got %h want 00000003", lo); end
        @(negedge clk);
        op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        lo_we = 1'b1; wdata = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        lo_we = 1'b0;
        n_cmp++; if (lo !== 32'd3) begin n_err++; $display("FAIL mtlo_busy got %h want 00000003", lo); end
        lat = -1;
        for (int e = 2; e <= 100; e++) begin
            @(posedge clk); #1;
            if (done) begin lat = e; break; end
        end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mtlo_latency got %0d want 33", lat); end
        n_cmp++; if (lo !== 32'h0000_000E) begin n_err++; $display("FAIL mtlo_result_lo got %h want 0000000e", lo); end
        n_cmp++; if (hi !== 32'h0000_0002) begin n_err++; $display("FAIL mtlo_result_hi got %h want 00000002", hi); end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_divu();
        test_div_zero();
        test_signed();
        test_ignore_and_reset();
        test_mthi_mtlo();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
